// File: rtl/subbytes_sequencer_pkg.sv
// Shared AES SubBytes sequencing definitions.
// Holds the default S-box latency and word count, the sequencer FSM encoding and
// the helper that maps a word index to its bit offset inside the 128-bit state.
package subbytes_sequencer_pkg;

  localparam int unsigned SBOX_LAT_DEF = 6;   // pipelined S-box depth, word in to word out
  localparam int unsigned WORDS_DEF    = 8;   // 16-bit words per 128-bit state
  localparam int unsigned WORD_W       = 16;
  localparam int unsigned STATE_W      = 128;

  typedef enum logic [1:0] {
    StIdle,
    StFeed,
    StDrain,
    StDone
  } seq_state_e;

  // Bit offset of word idx; word 0 occupies bits [15:0] so byte 0 stays at [7:0].
  function automatic int unsigned word_lo(input int unsigned idx);
    return idx * WORD_W;
  endfunction

endpackage

// File: rtl/sbox_word_collector.sv
// Reassembles the words returned by the external S-box pipeline into a 128-bit state.
// Ports:
//   clk, rst   - rising-edge clock, asynchronous active-high reset
//   start      - new operation accepted this cycle; clears both counters
//   active     - sequencer is feeding or draining the S-box
//   sbox_dout  - word returned by the S-box pipeline
//   last       - the final word is being captured this cycle
//   state      - assembled SubBytes result (only meaningful once last has fired)
module sbox_word_collector
  import subbytes_sequencer_pkg::*;
#(
  parameter int unsigned SBOX_LAT = SBOX_LAT_DEF,
  parameter int unsigned WORDS    = WORDS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               active,
  input  logic [WORD_W-1:0]  sbox_dout,
  output logic               last,
  output logic [STATE_W-1:0] state
);

  localparam int unsigned CNT_W = $clog2(WORDS + SBOX_LAT + 1);

  logic [CNT_W-1:0]   lat_q, lat_d;   // cycles since feeding began, saturates at SBOX_LAT
  logic [CNT_W-1:0]   cap_q, cap_d;   // index of the next word to capture
  logic [STATE_W-1:0] asm_q, asm_d;
  logic               capture;

  // Word j was driven on feed cycle j, so it emerges SBOX_LAT cycles later; once the
  // latency window has elapsed every active cycle delivers the next word in order.
  assign capture = active && (lat_q == CNT_W'(SBOX_LAT)) && (cap_q < CNT_W'(WORDS));
  assign last    = capture && (cap_q == CNT_W'(WORDS - 1));
  assign state   = asm_q;

  always_comb begin
    lat_d = lat_q;
    cap_d = cap_q;
    asm_d = asm_q;
    if (start) begin
      lat_d = '0;
      cap_d = '0;
    end else if (active) begin
      if (lat_q != CNT_W'(SBOX_LAT)) begin
        lat_d = lat_q + CNT_W'(1);
      end
      if (capture) begin
        asm_d[word_lo(32'(cap_q)) +: WORD_W] = sbox_dout;
        cap_d = cap_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_q <= '0;
      cap_q <= '0;
      asm_q <= '0;
    end else begin
      lat_q <= lat_d;
      cap_q <= cap_d;
      asm_q <= asm_d;
    end
  end

endmodule

// File: rtl/subbytes_sequencer.sv
// Sequences one 128-bit AES state through an external 16-bit pipelined S-box.
// The state is latched on accept, fed one word per cycle, and the returned words
// are collected into out_state, which is presented until the consumer takes it.
// WORDS * 16 is expected to equal 128.
// Ports:
//   clk, rst             - rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    - input handshake; in_state is the AES state (byte 0 = [7:0])
//   sbox_din             - word driven into the S-box (zero outside feeding)
//   sbox_dout            - word returned SBOX_LAT cycles after it was driven
//   out_valid/out_ready  - output handshake; out_state is SubBytes(in_state)
module subbytes_sequencer
  import subbytes_sequencer_pkg::*;
#(
  parameter int unsigned SBOX_LAT = SBOX_LAT_DEF,
  parameter int unsigned WORDS    = WORDS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  output logic [WORD_W-1:0]  sbox_din,
  input  logic [WORD_W-1:0]  sbox_dout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state
);

  localparam int unsigned CNT_W = $clog2(WORDS + SBOX_LAT + 1);

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   feed_q, feed_d;
  logic [STATE_W-1:0] data_q, data_d;
  logic               in_ready_q;
  logic               accept;
  logic               cap_last;
  logic               busy;

  // in_ready is registered so it stays low throughout reset and rises on the
  // first edge afterwards; it otherwise tracks state_q == StIdle exactly.
  assign in_ready  = in_ready_q;
  assign accept    = in_valid && in_ready_q;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StFeed) || (state_q == StDrain);

  always_comb begin
    state_d = state_q;
    feed_d  = feed_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StFeed;
          feed_d  = '0;
          data_d  = in_state;
        end
      end
      StFeed: begin
        feed_d = feed_q + CNT_W'(1);
        if (feed_q == CNT_W'(WORDS - 1)) begin
          // A zero-latency S-box finishes capture during the last feed cycle.
          state_d = cap_last ? StDone : StDrain;
        end
      end
      StDrain: begin
        if (cap_last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sbox_din = '0;
    if (state_q == StFeed) begin
      sbox_din = data_q[word_lo(32'(feed_q)) +: WORD_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      feed_q     <= '0;
      data_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      feed_q     <= feed_d;
      data_q     <= data_d;
      in_ready_q <= (state_d == StIdle);
    end
  end

  // Counters restart on accept, so words still in flight from an aborted
  // operation fall inside the latency window and are never captured.
  sbox_word_collector #(
    .SBOX_LAT (SBOX_LAT),
    .WORDS    (WORDS)
  ) u_collector (
    .clk       (clk),
    .rst       (rst),
    .start     (accept),
    .active    (busy),
    .sbox_dout (sbox_dout),
    .last      (cap_last),
    .state     (out_state)
  );

endmodule
